generic_dsp_param: RTL and testbench

Cycle-accurate behavioural model of a DSP48E2-style multiply-accumulate slice for the FIOS Montgomery datapath, generalised from the fixed 17-bit cascade model. Word width, input/multiplier/C pipeline depth and shift amount are parameters. It adds a P-feedback W operand, a shifted-PCIN Z operand, subtract mode, a global clock enable, carry-out and a valid pipeline. Instances chain through PCIN_i/PCOUT_o to form the multi-word multiplier columns.

---
 rtl/dsp_pkg.sv | 27 ++
 rtl/dsp_delay_line.sv | 32 +++
 rtl/generic_dsp_param.sv | 130 +++++++++++++
 tb/tb_generic_dsp_param.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared constants for the parameterised DSP MAC slice
package dsp_pkg;

  localparam int P_W     = 48;
  localparam int A_EXT_W = 30;
  localparam int B_EXT_W = 18;

  // OPMODE field encodings: W=[8:7], Z=[6:4], XY=[3:0]
  localparam logic [1:0] W_ZERO     = 2'b00;
  localparam logic [1:0] W_P        = 2'b10;
  localparam logic [1:0] W_C        = 2'b11;
  localparam logic [3:0] XY_ZERO    = 4'b0000;
  localparam logic [3:0] XY_M       = 4'b0101;
  localparam logic [2:0] Z_ZERO     = 3'b000;
  localparam logic [2:0] Z_PCIN     = 3'b001;
  localparam logic [2:0] Z_P        = 3'b010;
  localparam logic [2:0] Z_PCIN_SHR = 3'b101;
  localparam logic [2:0] Z_P_SHR    = 3'b110;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0011;

  function automatic logic [8:0] make_opmode(logic [1:0] w, logic [2:0] z, logic [3:0] xy);
    return {w, z, xy};
  endfunction

endpackage

// File: rtl/dsp_delay_line.sv
// rtl/dsp_delay_line.sv - clock-enabled shift register; depth 0 degenerates to a wire
module dsp_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_reg
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (ce_i) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/generic_dsp_param.sv
// rtl/generic_dsp_param.sv - DSP48E2-style MAC slice with cascade, subtract and valid pipeline
module generic_dsp_param
  import dsp_pkg::*;
#(
  parameter int WORD_W = 17,
  parameter int ABREG  = 1,
  parameter int MREG   = 1,
  parameter int CREG   = 1,
  parameter int SHIFT  = WORD_W
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  ce_i,
  input  logic                  CREG_en_i,
  input  logic                  valid_i,
  input  logic [8:0]            OPMODE_i,
  input  logic [3:0]            ALUMODE_i,
  input  logic [WORD_W-1:0]     A_i,
  input  logic [WORD_W-1:0]     B_i,
  input  logic [2*WORD_W-1:0]   C_i,
  input  logic [P_W-1:0]        PCIN_i,
  output logic [2*WORD_W-1:0]   P_o,
  output logic [P_W-1:0]        PCOUT_o,
  output logic                  CARRY_o,
  output logic                  valid_o
);

  localparam int DSP_REG_LEVEL = 1 + ABREG + MREG;

  logic [WORD_W-1:0]  a_d, b_d;
  logic [A_EXT_W-1:0] a_ext;
  logic [B_EXT_W-1:0] b_ext;
  logic [P_W-1:0]     m_comb, m_q, m_use;
  logic [P_W-1:0]     c_ext, c_q, c_use;
  logic [8:0]         opmode_q;
  logic [3:0]         alumode_q;
  logic               valid_m;
  logic [P_W-1:0]     p_q;
  logic               carry_q, valid_q;

  dsp_delay_line #(.WIDTH(WORD_W), .DEPTH(ABREG)) u_a_line (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .ce_i(ce_i), .din(A_i), .dout(a_d)
  );
  dsp_delay_line #(.WIDTH(WORD_W), .DEPTH(ABREG)) u_b_line (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .ce_i(ce_i), .din(B_i), .dout(b_d)
  );
  // valid rides the A/B and M stages; the P stage adds the final cycle
  dsp_delay_line #(.WIDTH(1), .DEPTH(ABREG + MREG)) u_valid_line (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .ce_i(ce_i), .din(valid_i), .dout(valid_m)
  );

  assign a_ext  = {{(A_EXT_W-WORD_W){1'b0}}, a_d};
  assign b_ext  = {{(B_EXT_W-WORD_W){1'b0}}, b_d};
  assign m_comb = {{(P_W-A_EXT_W){1'b0}}, a_ext} * {{(P_W-B_EXT_W){1'b0}}, b_ext};
  assign c_ext  = {{(P_W-2*WORD_W){1'b0}}, C_i};

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      m_q       <= '0;
      c_q       <= '0;
      opmode_q  <= '0;
      alumode_q <= '0;
    end else if (ce_i) begin
      m_q       <= m_comb;
      opmode_q  <= OPMODE_i;
      alumode_q <= ALUMODE_i;
      if (CREG_en_i) c_q <= c_ext;
    end
  end

  assign m_use = (MREG != 0) ? m_q : m_comb;
  assign c_use = (CREG != 0) ? c_q : c_ext;

  logic [P_W-1:0] w_op, xy_op, z_op;
  logic [P_W+1:0] add_sum;
  logic [P_W:0]   wxy_sum, sub_diff;
  logic [P_W-1:0] p_next;
  logic           carry_next;

  always_comb begin
    w_op = '0;
    case (opmode_q[8:7])
      W_P:     w_op = p_q;
      W_C:     w_op = c_use;
      default: w_op = '0;
    endcase

    xy_op = (opmode_q[3:0] == XY_M) ? m_use : '0;

    z_op = '0;
    case (opmode_q[6:4])
      Z_PCIN:     z_op = PCIN_i;
      Z_P:        z_op = p_q;
      Z_PCIN_SHR: z_op = PCIN_i >> SHIFT;
      Z_P_SHR:    z_op = p_q >> SHIFT;
      default:    z_op = '0;
    endcase
  end

  // widened arithmetic so carry/borrow fall out of the top bits
  always_comb begin
    add_sum  = {2'b00, z_op} + {2'b00, w_op} + {2'b00, xy_op};
    wxy_sum  = {1'b0, w_op} + {1'b0, xy_op};
    sub_diff = {1'b0, z_op} - wxy_sum;
    p_next     = add_sum[P_W-1:0];
    carry_next = |add_sum[P_W+1:P_W];
    if (alumode_q == ALU_SUB) begin
      p_next     = sub_diff[P_W-1:0];
      carry_next = ({1'b0, z_op} < wxy_sum);
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      p_q     <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (ce_i) begin
      p_q     <= p_next;
      carry_q <= carry_next;
      valid_q <= valid_m;
    end
  end

  assign P_o     = p_q[2*WORD_W-1:0];
  assign PCOUT_o = p_q;
  assign CARRY_o = carry_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_generic_dsp_param.sv
// tb/tb_generic_dsp_param.sv - directed-vector bench for generic_dsp_param
module tb_generic_dsp_param;
  import dsp_pkg::*;

  logic        clock, reset_n, ce, creg_en, valid;
  logic [8:0]  opmode;
  logic [3:0]  alumode;
  logic [16:0] a, b;
  logic [33:0] c;
  logic [47:0] pcin;

  logic [33:0] p1, p2;
  logic [47:0] pcout1, pcout2;
  logic        carry1, carry2, valid1, valid2;

  int n_tests = 0;
  int n_fail  = 0;

  generic_dsp_param u_dut (
    .clock_i(clock), .reset_n_i(reset_n), .ce_i(ce), .CREG_en_i(creg_en), .valid_i(valid),
    .OPMODE_i(opmode), .ALUMODE_i(alumode), .A_i(a), .B_i(b), .C_i(c), .PCIN_i(pcin),
    .P_o(p1), .PCOUT_o(pcout1), .CARRY_o(carry1), .valid_o(valid1)
  );

  generic_dsp_param #(.ABREG(2)) u_dut_ab2 (
    .clock_i(clock), .reset_n_i(reset_n), .ce_i(ce), .CREG_en_i(creg_en), .valid_i(valid),
    .OPMODE_i(opmode), .ALUMODE_i(alumode), .A_i(a), .B_i(b), .C_i(c), .PCIN_i(pcin),
    .P_o(p2), .PCOUT_o(pcout2), .CARRY_o(carry2), .valid_o(valid2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [8:0] op_hold, op_m, op_c;

  initial begin
    op_hold = make_opmode(W_ZERO, Z_P, XY_ZERO);
    op_m    = make_opmode(W_ZERO, Z_ZERO, XY_M);
    op_c    = make_opmode(W_C, Z_ZERO, XY_ZERO);

    reset_n = 1'b0; ce = 1'b1; creg_en = 1'b1; valid = 1'b0;
    opmode = '0; alumode = ALU_ADD; a = '0; b = '0; c = '0; pcin = '0;
    tick(); tick();
    check("reset_p", p1, 0);
    check("reset_pcout", pcout1, 0);
    check("reset_carry", carry1, 0);
    check("reset_valid", valid1, 0);
    reset_n = 1'b1;

    // 1: full-scale product, latency 3 (ABREG=1) and 4 (ABREG=2)
    a = 17'h1FFFF; b = 17'h1FFFF; opmode = op_m; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    check("t1_valid_early", valid1, 0);
    tick();
    check("t1_valid", valid1, 1);
    check("t1_p", p1, 34'h3FFFC0001);
    check("t1_carry", carry1, 0);
    check("t1_ab2_valid_early", valid2, 0);
    tick();
    check("t1_ab2_valid", valid2, 1);
    check("t1_ab2_p", p2, 34'h3FFFC0001);
    check("t1_valid_drop", valid1, 0);

    // 2: preload P from C, then shifted P plus M
    a = 17'd2; b = 17'd3; c = 34'h60000; opmode = op_c;
    tick(); tick();
    check("t2_preload", pcout1, 48'h60000);
    opmode = make_opmode(W_ZERO, Z_P_SHR, XY_M);
    tick();
    opmode = op_hold;
    tick();
    check("t2_shr_mac", p1, 34'd9);

    // C register ignores C_i when its load enable is low
    creg_en = 1'b0; c = 34'h123; opmode = op_c;
    tick(); tick();
    check("creg_en_hold", pcout1, 48'h60000);
    creg_en = 1'b1;

    // 3: cascade input, shifted and unshifted
    pcin = 48'h1_0000_0000; opmode = make_opmode(W_ZERO, Z_PCIN_SHR, XY_ZERO);
    tick(); tick();
    check("t3_pcin_shr", p1, 34'h8000);
    opmode = make_opmode(W_ZERO, Z_PCIN, XY_ZERO);
    tick(); tick();
    check("t3_pcin", pcout1, 48'h1_0000_0000);
    check("t3_pcin_p", p1, 34'h1_0000_0000);

    // 4: subtract, without and with borrow
    c = 34'd100; opmode = op_c;
    tick(); tick();
    c = 34'd10; opmode = make_opmode(W_C, Z_P, XY_ZERO); alumode = ALU_SUB;
    tick();
    opmode = op_hold; alumode = ALU_ADD;
    tick();
    check("t4_sub_p", p1, 34'd90);
    check("t4_sub_carry", carry1, 0);
    c = 34'd200; opmode = make_opmode(W_C, Z_P, XY_ZERO); alumode = ALU_SUB;
    tick();
    opmode = op_hold; alumode = ALU_ADD;
    tick();
    check("t4_borrow_pcout", pcout1, 48'hFFFF_FFFF_FF92);
    check("t4_borrow_p", p1, 34'h3FFFFFF92);
    check("t4_borrow_carry", carry1, 1);

    // 5: clock enable freezes everything, including the carry flag
    ce = 1'b0;
    tick(); tick();
    check("t5_frozen_carry", carry1, 1);
    check("t5_frozen_pcout", pcout1, 48'hFFFF_FFFF_FF92);
    ce = 1'b1;
    a = 17'd5; b = 17'd7; opmode = op_m; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick(); tick();
    check("t5_p", p1, 34'd35);
    check("t5_valid", valid1, 1);
    ce = 1'b0; a = 17'd9;
    tick(); tick();
    check("t5_frozen_valid", valid1, 1);
    check("t5_frozen_p", p1, 34'd35);
    ce = 1'b1;
    tick();
    check("t5_resume_valid", valid1, 0);

    // stall inserted mid-flight stretches latency by exactly the stalled cycles
    a = 17'd4; b = 17'd4; valid = 1'b1;
    tick();
    valid = 1'b0; ce = 1'b0;
    tick(); tick();
    ce = 1'b1;
    tick();
    check("t5_stall_valid_early", valid1, 0);
    tick();
    check("t5_stall_valid", valid1, 1);
    check("t5_stall_p", p1, 34'd16);
    check("t5_stall_ab2_early", valid2, 0);
    tick();
    check("t5_stall_ab2_valid", valid2, 1);
    check("t5_stall_ab2_p", p2, 34'd16);

    // 6: asynchronous reset with two samples in flight
    a = 17'd3; b = 17'd3; valid = 1'b1;
    tick(); tick();
    valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_p", p1, 0);
    check("t6_async_pcout", pcout1, 0);
    check("t6_async_valid", valid1, 0);
    check("t6_async_carry", carry1, 0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t6_no_stale_valid_%0d", i), valid1, 0);
      check($sformatf("t6_no_stale_ab2_%0d", i), valid2, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
